// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and sizing helper for the shift-add multiplier
package seq_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Step counter only has to reach W-1; keep at least one bit for W=2.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/seq_mult_core_abs_neg.sv
// rtl/seq_mult_core_abs_neg.sv - combinational conditional two's-complement negate
// Used both as |x| on operand entry and to re-apply the sign to the result.
module abs_neg #(
   parameter int WIDTH = 8
) (
   input  logic             neg_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      dout = neg_en ? (~din + WIDTH'(1)) : din;
   end

endmodule

// File: rtl/seq_mult_core.sv
// rtl/seq_mult_core.sv - parametrised sequential shift-add multiplier, signed/unsigned
// Magnitudes are multiplied unsigned; the sign is applied once on the final step.
module seq_mult_core
   import seq_mult_pkg::*;
#(
   parameter int W          = 8,
   parameter int EARLY_TERM = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [W-1:0]   multiplicand,
   input  logic [W-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = cnt_width(W);

   state_e           state_q, state_d;
   logic [2*W-1:0]   mcand_q, mcand_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   product_q, product_d;
   logic [W-1:0]     mag_b_q, mag_b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;

   logic [W-1:0]     mag_a_in, mag_b_in;
   logic [2*W-1:0]   acc_next, result;
   logic             last_step;

   abs_neg #(.WIDTH(W)) u_abs_a (
      .neg_en (signed_mode & multiplicand[W-1]),
      .din    (multiplicand),
      .dout   (mag_a_in)
   );

   abs_neg #(.WIDTH(W)) u_abs_b (
      .neg_en (signed_mode & multiplier[W-1]),
      .din    (multiplier),
      .dout   (mag_b_in)
   );

   abs_neg #(.WIDTH(2*W)) u_sign_res (
      .neg_en (neg_q),
      .din    (acc_next),
      .dout   (result)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
         mag_b_q   <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         mag_b_q   <= mag_b_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
      end
   end

   always_comb begin
      acc_next  = mag_b_q[0] ? (acc_q + mcand_q) : acc_q;
      // Early exit once no set multiplier bits remain above the one consumed now.
      last_step = (cnt_q == CW'(W - 1)) ||
                  ((EARLY_TERM != 0) && ((mag_b_q >> 1) == '0));

      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      product_d = product_q;
      mag_b_d   = mag_b_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mcand_d = {{W{1'b0}}, mag_a_in};
               mag_b_d = mag_b_in;
               neg_d   = signed_mode & (multiplicand[W-1] ^ multiplier[W-1]);
               acc_d   = '0;
               cnt_d   = '0;
               if ((mag_a_in == '0) || (mag_b_in == '0)) begin
                  product_d = '0;
                  state_d   = ST_DONE;
               end else begin
                  state_d   = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            acc_d   = acc_next;
            mcand_d = mcand_q << 1;
            mag_b_d = mag_b_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (last_step) begin
               product_d = result;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clr) begin
         state_d   = ST_IDLE;
         product_d = '0;
      end
   end

   always_comb begin
      busy    = (state_q == ST_RUN);
      done    = (state_q == ST_DONE);
      product = product_q;
   end

endmodule

// File: tb/tb_seq_mult_core.sv
// tb/tb_seq_mult_core.sv - self-checking bench for seq_mult_core, W=8, both EARLY_TERM settings
module tb_seq_mult_core;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic        start = 1'b0;
   logic        start0 = 1'b0;
   logic        sm = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        busy, done, busy0, done0;
   logic [15:0] product, product0;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        sm;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] p;
      int          lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   seq_mult_core #(.W(8), .EARLY_TERM(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .start        (start),
      .signed_mode  (sm),
      .multiplicand (a),
      .multiplier   (b),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   seq_mult_core #(.W(8), .EARLY_TERM(0)) dut0 (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .start        (start0),
      .signed_mode  (sm),
      .multiplicand (a),
      .multiplier   (b),
      .busy         (busy0),
      .done         (done0),
      .product      (product0)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] model_prod(input logic vsm, input logic [7:0] va, input logic [7:0] vb);
      logic signed [15:0] sp;
      if (vsm) begin
         sp = $signed(va) * $signed(vb);
         return sp;
      end
      return {8'd0, va} * {8'd0, vb};
   endfunction

   function automatic int model_lat(input logic vsm, input logic [7:0] va, input logic [7:0] vb, input bit et);
      logic [7:0] mb;
      mb = (vsm && vb[7]) ? (~vb + 8'd1) : vb;
      if (va == 8'd0 || mb == 8'd0) return 1;
      if (!et) return 9;
      for (int i = 7; i >= 0; i--) if (mb[i]) return i + 2;
      return 1;
   endfunction

   task automatic run_op(input bit sel, input logic vsm, input logic [7:0] va, input logic [7:0] vb,
                         input logic [15:0] ep, input int elat, input bit repulse, input string name);
      exp_t e;
      int   edges;
      int   bcnt;
      @(negedge clk);
      sm = vsm; a = va; b = vb;
      if (sel) start0 = 1'b1; else start = 1'b1;
      sb.push_back('{ep, elat});
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      start = 1'b0; start0 = 1'b0;
      if (repulse) begin
         a = ~va; b = 8'd200; sm = ~vsm; start = 1'b1;
      end
      bcnt = 0;
      while (!(sel ? done0 : done) && edges < 40) begin
         if (sel ? busy0 : busy) bcnt++;
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      start = 1'b0;
      e = sb.pop_front();
      check({name, " latency"}, edges, e.lat);
      check({name, " product"}, sel ? product0 : product, e.p);
      check({name, " busy_cycles"}, bcnt, e.lat - 1);
      @(negedge clk);
      check({name, " done_width"}, sel ? done0 : done, 1'b0);
   endtask

   vec_t vecs[9];

   initial begin
      logic [7:0] ra, rb;
      logic       rs;
      int         seen;

      vecs[0] = '{1'b0, 8'd13,  8'd7,   16'h005B, 4};
      vecs[1] = '{1'b0, 8'd4,   8'd15,  16'd60,   5};
      vecs[2] = '{1'b0, 8'd255, 8'd255, 16'hFE01, 9};
      vecs[3] = '{1'b1, 8'hFD,  8'd5,   16'hFFF1, 4};
      vecs[4] = '{1'b1, 8'h80,  8'h80,  16'h4000, 9};
      vecs[5] = '{1'b0, 8'd0,   8'd37,  16'd0,    1};
      vecs[6] = '{1'b1, 8'h45,  8'd0,   16'd0,    1};
      vecs[7] = '{1'b1, 8'h7F,  8'hFF,  16'hFF81, 2};
      vecs[8] = '{1'b0, 8'd1,   8'd128, 16'd128,  9};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset product", product, 16'd0);
      check("reset product et0", product0, 16'd0);
      rst = 1'b1;

      for (int i = 0; i < 9; i++)
         run_op(1'b0, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat, 1'b0,
                $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_op(1'b0, rs, ra, rb, model_prod(rs, ra, rb), model_lat(rs, ra, rb, 1'b1), 1'b0,
                $sformatf("rnd%0d", i));
      end

      run_op(1'b0, 1'b0, 8'd13, 8'd7, 16'h005B, 4, 1'b1, "restart_ignored");
      run_op(1'b1, 1'b0, 8'd9, 8'd1, 16'd9, 9, 1'b0, "et0_b1");
      run_op(1'b1, 1'b1, 8'hF6, 8'h03, 16'hFFE2, 9, 1'b0, "et0_signed");

      // clr during the second RUN cycle
      @(negedge clk);
      sm = 1'b0; a = 8'd255; b = 8'd255; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("clr pre busy", busy, 1'b1);
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      check("clr busy", busy, 1'b0);
      check("clr done", done, 1'b0);
      check("clr product", product, 16'd0);
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         @(negedge clk);
         if (done) seen++;
      end
      check("clr no_done", seen, 0);

      // reset mid-RUN
      @(negedge clk);
      a = 8'd200; b = 8'd100; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst product", product, 16'd0);
      rst = 1'b1;

      run_op(1'b0, 1'b0, 8'd200, 8'd100, 16'd20000, 8, 1'b0, "after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_mult_core.md
Name: seq_mult_core

Overview:
Parametrised sequential shift-add multiplier core. It is the successor to the fixed 8x8 unsigned multiplier behind the board wrapper (BTNC start, 7-segment display).
- Adds: generic operand width, a signed/unsigned mode, a start/busy/done handshake, synchronous abort, and optional early termination.
- Sits between the button/debounce front end and the display/product register path.

Parameters:
W, 8, operand width in bits (W >= 2); product is 2W bits.
EARLY_TERM, 1, 1 = stop stepping once the remaining multiplier bits are all zero; 0 = always W steps.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-low reset (rst=0 sampled at a rising edge resets the block).
clr  in  1  synchronous abort/clear, active-high.
start  in  1  request; sampled only in IDLE.
signed_mode  in  1  1 = two's-complement operands; latched at start.
multiplicand  in  W  operand A; latched at start.
multiplier  in  W  operand B; latched at start.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse; product valid and updated.
product  out  2W  result register; holds until next completion, clr or reset.

Behaviour:
- Reset (rst=0 at edge): state=IDLE, busy=0, done=0, product=0, all internal registers 0. Reset overrides everything, including mid-RUN.
- clr=1 at edge (rst=1): state=IDLE, product=0, done=0. The in-flight operation is discarded and no done is produced. clr has priority over start.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch mag_a=|A|, mag_b=|B|; the absolute value applies only when signed_mode=1, otherwise raw bits.
  - latch neg = signed_mode & (A[W-1] ^ B[W-1]); acc=0; step count=0.
  - If mag_a==0 or mag_b==0: product<=0, done<=1, go to DONE. Latency is 1 edge.
  - Otherwise go to RUN.
- RUN step at each edge:
  - if mag_b[0]: acc += mcand_sh.
  - mcand_sh <<= 1 (2W wide); mag_b >>= 1; count++.
  - Last step when count==W-1, or (EARLY_TERM and mag_b>>1 == 0).
  - On the last step: product <= neg ? -(acc_next) : acc_next (2W-bit two's complement); done<=1; go to DONE.
- Step count n:
  - EARLY_TERM=0: n=W.
  - EARLY_TERM=1: n = position of highest set bit of |B| + 1.
  - done is high in the cycle after edge E(n), i.e. n+1 edges after start is sampled.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in RUN and DONE; no queuing.
- Signed corner: |-2^(W-1)| = 2^(W-1) is held unsigned in W bits. (-2^(W-1))^2 = 2^(2W-2) fits in 2W signed. No overflow is possible.
- Unsigned mode: pure W x W -> 2W, no sign handling.
- busy=1 exactly while state==RUN.
- Operand input changes after E0 have no effect.

Decomposition:
- Package seq_mult_pkg:
  - state encoding constants IDLE/RUN/DONE (2-bit);
  - width helper function for the count register (clog2(W)).
- Sub-module abs_neg (parametrised width): combinational conditional absolute value / conditional negate. Instantiated for A, B (W bits) and for the result (2W bits).
- FSM, shift registers and accumulator stay in seq_mult_core.

Test Plan:
1. W=8, EARLY_TERM=1, unsigned, A=13, B=7, start pulse -> busy for 3 cycles; done 4 edges after start; product=91 (0x005B).
2. Unsigned A=4, B=15 back-to-back after test 1 -> product=60. Also A=255, B=255 -> product=65025 (0xFE01), done after 9 edges.
3. Signed A=-3 (0xFD), B=5 -> product=0xFFF1 (-15). Signed A=0x80, B=0x80 -> product=0x4000 (16384).
4. A=0 or B=0 in either mode -> done 1 edge after start, product=0, busy never asserted.
5. Start re-pulsed while busy with different operands -> ignored; first result delivered unchanged. With EARLY_TERM=0, B=1 -> done exactly 9 edges after start.
6. clr=1 in 2nd RUN cycle -> IDLE, product=0, no done pulse. rst=0 mid-RUN -> all outputs 0 at next edge. After release, a new start completes normally.
